// File: rtl/i2c_reg_slave.sv
// rtl/i2c_reg_slave.sv - I2C slave bridging a 16-bit register pointer to a simple register bus
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h59,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO, WDAT, ACK_WDAT, RDAT, MACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  rx, rx_n, tx, tx_n, ahi, ahi_n, wdata, wdata_n;
  logic [15:0] ptr, ptr_n;
  logic        oe, oe_n, wr, wr_n, rd, rd_n, rd_pend, busy_r, busy_n;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign sda_oe    = oe;
  assign reg_addr  = ptr;
  assign reg_wdata = wdata;
  assign reg_wr    = wr;
  assign reg_rd    = rd;
  assign busy      = busy_r;

  // Bring the asynchronous bus lines into the clk domain and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      rx      <= 8'h00;
      tx      <= 8'h00;
      ahi     <= 8'h00;
      wdata   <= 8'h00;
      ptr     <= 16'h0000;
      oe      <= 1'b0;
      wr      <= 1'b0;
      rd      <= 1'b0;
      rd_pend <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      rx      <= rx_n;
      tx      <= tx_n;
      ahi     <= ahi_n;
      wdata   <= wdata_n;
      ptr     <= ptr_n;
      oe      <= oe_n;
      wr      <= wr_n;
      rd      <= rd_n;
      rd_pend <= rd;
      busy_r  <= busy_n;
    end
  end

  // Next-state logic: bits shift in on SCL rise, SDA drive changes only after SCL fall
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rx_n      = rx;
    tx_n      = tx;
    ahi_n     = ahi;
    wdata_n   = wdata;
    ptr_n     = ptr;
    oe_n      = oe;
    wr_n      = 1'b0;
    rd_n      = 1'b0;
    busy_n    = busy_r;

    // Read data lands the clk after the request; the pointer advances once the byte is held
    if (rd_pend) begin
      tx_n  = reg_rdata;
      ptr_n = ptr + 16'd1;
    end
    if (wr) ptr_n = ptr + 16'd1;

    if (start_det) begin
      state_n   = DEV;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b0;
    end else if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else begin
      case (state)
        DEV, AHI, ALO, WDAT: begin
          if (scl_rise) begin
            rx_n      = {rx[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (state == ALO && bit_cnt == 4'd7) ptr_n = {ahi, rx[6:0], sda_s};
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            oe_n      = 1'b1;
            case (state)
              DEV: begin
                if (rx[7:1] == SLAVE_ADDR) begin
                  state_n = ACK_DEV;
                  rd_n    = rx[0];
                end else begin
                  state_n = IDLE;
                  oe_n    = 1'b0;
                end
              end
              AHI: begin
                state_n = ACK_AHI;
                ahi_n   = rx;
              end
              ALO: state_n = ACK_ALO;
              default: begin
                state_n = ACK_WDAT;
                wr_n    = 1'b1;
                wdata_n = rx;
              end
            endcase
          end
        end
        ACK_DEV, ACK_AHI, ACK_ALO, ACK_WDAT: begin
          if (scl_fall) begin
            bit_cnt_n = 4'd0;
            oe_n      = 1'b0;
            case (state)
              ACK_DEV: begin
                if (rx[0]) begin
                  state_n = RDAT;
                  oe_n    = ~tx[7];
                end else begin
                  state_n = AHI;
                end
              end
              ACK_AHI: state_n = ALO;
              default: state_n = WDAT;
            endcase
          end
        end
        RDAT: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n = MACK;
              oe_n    = 1'b0;
            end else begin
              tx_n = {tx[6:0], 1'b0};
              oe_n = ~tx[6];
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda_s) state_n = IDLE;
            else       rd_n    = 1'b1;
          end else if (scl_fall) begin
            state_n   = RDAT;
            bit_cnt_n = 4'd0;
            oe_n      = ~tx[7];
          end
        end
        default: ;
      endcase
    end

    if (state_n == ACK_DEV)   busy_n = 1'b1;
    else if (state_n == IDLE) busy_n = 1'b0;
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb/tb_i2c_reg_slave.sv - directed bus-level bench for i2c_reg_slave
module tb_i2c_reg_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, reg_wr, reg_rd, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata = 8'h00;

  int total = 0;
  int bad   = 0;

  logic [7:0]  wr_cnt = 8'd0;
  logic [7:0]  rd_cnt = 8'd0;
  logic [7:0]  both_cnt = 8'd0;
  logic [15:0] wr_addr_log [0:15];
  logic [7:0]  wr_data_log [0:15];
  logic [15:0] rd_addr_log [0:15];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_reg_slave dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Register-side model: logs strobes and answers reads one clk after reg_rd
  always @(posedge clk) begin
    if (reg_wr) begin
      wr_addr_log[wr_cnt[3:0]] <= reg_addr;
      wr_data_log[wr_cnt[3:0]] <= reg_wdata;
      wr_cnt <= wr_cnt + 8'd1;
    end
    if (reg_rd) begin
      rd_addr_log[rd_cnt[3:0]] <= reg_addr;
      rd_cnt <= rd_cnt + 8'd1;
      reg_rdata <= (reg_addr == 16'h0010) ? 8'h5A :
                   (reg_addr == 16'h0011) ? 8'hC3 : 8'hEE;
    end
    if (reg_wr && reg_rd) both_cnt <= both_cnt + 8'd1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected test done");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; q();
    scl_m = 1'b1; q(); q();
    scl_m = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    b = sda_bus; q();
    scl_m = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    logic [7:0] w0, r0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_reg_addr", 32'(reg_addr), 0);
    chk("rst_reg_wdata", 32'(reg_wdata), 0);
    chk("rst_reg_wr", 32'(reg_wr), 0);
    chk("rst_reg_rd", 32'(reg_rd), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    q();

    // Single write 0x1234 <= 0xAB
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hB2, ack); chk("w1_ack_dev", 32'(ack), 0);
    chk("w1_busy", 32'(busy), 1);
    write_byte(8'h12, ack); chk("w1_ack_ahi", 32'(ack), 0);
    write_byte(8'h34, ack); chk("w1_ack_alo", 32'(ack), 0);
    write_byte(8'hAB, ack); chk("w1_ack_wdat", 32'(ack), 0);
    i2c_stop(); q();
    chk("w1_wr_count", 32'(wr_cnt - w0), 1);
    chk("w1_wr_addr", 32'(wr_addr_log[w0[3:0]]), 'h1234);
    chk("w1_wr_data", 32'(wr_data_log[w0[3:0]]), 'hAB);
    chk("w1_ptr_after", 32'(reg_addr), 'h1235);
    chk("w1_busy_after", 32'(busy), 0);

    // Burst write across the pointer wrap
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hB2, ack);
    write_byte(8'hFF, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack); chk("burst_ack0", 32'(ack), 0);
    write_byte(8'h22, ack); chk("burst_ack1", 32'(ack), 0);
    write_byte(8'h33, ack); chk("burst_ack2", 32'(ack), 0);
    i2c_stop(); q();
    chk("burst_wr_count", 32'(wr_cnt - w0), 3);
    chk("burst_addr0", 32'(wr_addr_log[w0[3:0]]), 'hFFFF);
    chk("burst_addr1", 32'(wr_addr_log[w0[3:0] + 4'd1]), 'h0000);
    chk("burst_addr2", 32'(wr_addr_log[w0[3:0] + 4'd2]), 'h0001);
    chk("burst_data2", 32'(wr_data_log[w0[3:0] + 4'd2]), 'h33);
    chk("burst_ptr_after", 32'(reg_addr), 'h0002);

    // Random read from 0x0010: ACK then NACK
    w0 = wr_cnt;
    r0 = rd_cnt;
    i2c_start();
    write_byte(8'hB2, ack);
    write_byte(8'h00, ack);
    write_byte(8'h10, ack);
    i2c_start();
    write_byte(8'hB3, ack); chk("rr_ack_dev", 32'(ack), 0);
    read_byte(d, 1'b0); chk("rr_byte0", 32'(d), 'h5A);
    read_byte(d, 1'b1); chk("rr_byte1", 32'(d), 'hC3);
    chk("rr_busy_after_nack", 32'(busy), 0);
    chk("rr_oe_after_nack", 32'(sda_oe), 0);
    i2c_stop(); q();
    chk("rr_rd_count", 32'(rd_cnt - r0), 2);
    chk("rr_rd_addr0", 32'(rd_addr_log[r0[3:0]]), 'h0010);
    chk("rr_rd_addr1", 32'(rd_addr_log[r0[3:0] + 4'd1]), 'h0011);
    chk("rr_no_wr", 32'(wr_cnt - w0), 0);

    // Foreign address 0x58 is ignored
    w0 = wr_cnt;
    r0 = rd_cnt;
    i2c_start();
    write_byte(8'hB0, ack); chk("nm_nack", 32'(ack), 1);
    chk("nm_busy", 32'(busy), 0);
    write_byte(8'h00, ack); chk("nm_nack2", 32'(ack), 1);
    i2c_stop(); q();
    chk("nm_no_wr", 32'(wr_cnt - w0), 0);
    chk("nm_no_rd", 32'(rd_cnt - r0), 0);

    // STOP after 4 data bits discards the partial byte
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hB2, ack);
    write_byte(8'h00, ack);
    write_byte(8'h20, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop(); q();
    chk("part_no_wr", 32'(wr_cnt - w0), 0);
    chk("part_busy", 32'(busy), 0);
    chk("part_ptr", 32'(reg_addr), 'h0020);
    i2c_start();
    write_byte(8'hB2, ack);
    write_byte(8'h00, ack);
    write_byte(8'h21, ack);
    write_byte(8'h5C, ack); chk("part_next_ack", 32'(ack), 0);
    i2c_stop(); q();
    chk("part_next_count", 32'(wr_cnt - w0), 1);
    chk("part_next_addr", 32'(wr_addr_log[w0[3:0]]), 'h0021);
    chk("part_next_data", 32'(wr_data_log[w0[3:0]]), 'h5C);

    // Reset during RDAT while the slave is pulling SDA low
    i2c_start();
    write_byte(8'hB2, ack);
    write_byte(8'h00, ack);
    write_byte(8'h10, ack);
    i2c_start();
    write_byte(8'hB3, ack);
    read_bit(b); chk("rst_rd_bit0", 32'(b), 0);
    read_bit(b); chk("rst_rd_bit1", 32'(b), 1);
    chk("rst_rd_oe_before", 32'(sda_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_oe_next", 32'(sda_oe), 0);
    chk("rst_rd_ptr", 32'(reg_addr), 0);
    rst = 1'b0;
    read_bit(b); chk("rst_rd_released", 32'(b), 1);
    chk("rst_rd_busy", 32'(busy), 0);
    i2c_stop(); q();

    chk("never_wr_and_rd", 32'(both_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
